// File: rtl/vpi_stim_bank_if.sv
// Write port and per-channel output bundle of the stimulus bank.
// master = VPI task side that pushes words, slave = the bank itself.
interface vpi_stim_bank_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8
);
   localparam int CW = $clog2(CHANNELS);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                      wr_en;
   logic [CW-1:0]             wr_chan;
   logic [WIDTH-1:0]          wr_data;
   logic [CHANNELS-1:0]       mode;
   logic [CHANNELS*WIDTH-1:0] out_data;
   logic [CHANNELS-1:0]       out_valid;
   logic [CHANNELS-1:0]       out_ready;
   logic [CHANNELS*LW-1:0]    level;
   logic [CHANNELS-1:0]       overflow;
   logic [31:0]               cycle_count;

   modport master (
      output wr_en, wr_chan, wr_data, mode, out_ready,
      input  out_data, out_valid, level, overflow, cycle_count
   );

   modport slave (
      input  wr_en, wr_chan, wr_data, mode, out_ready,
      output out_data, out_valid, level, overflow, cycle_count
   );
endinterface

// File: rtl/vpi_stim_bank.sv
// Multi-channel stimulus source: one shared write port fills per-channel
// FIFOs; each channel drains either as a FWFT stream or into a held
// register that steps one word per cycle. Also provides a cycle timestamp.
module vpi_stim_bank #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8
) (
   input logic            clk_i,
   input logic            reset_n_i,
   vpi_stim_bank_if.slave bus_io
);
   localparam int CW = $clog2(CHANNELS);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);

   logic [31:0] cycle_q, cycle_d;

   assign cycle_d            = cycle_q + 32'd1;
   assign bus_io.cycle_count = cycle_q;

   // Free-running timestamp, wraps naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) cycle_q <= '0;
      else            cycle_q <= cycle_d;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [LW-1:0]    level_q, level_d;
      logic             overflow_q, overflow_d;
      logic [WIDTH-1:0] hold_q;
      logic             held_v_q;
      logic [WIDTH-1:0] head;
      logic             push, pop, accept, empty, full, hold_mode;

      // Out-of-range channel numbers never match, so such writes vanish.
      assign push      = bus_io.wr_en && (bus_io.wr_chan == CW'(c));
      assign hold_mode = bus_io.mode[c];
      assign empty     = (level_q == '0);
      assign full      = (level_q == LW'(DEPTH));
      assign head      = mem_q[rd_ptr_q];
      // Hold mode drains every cycle regardless of ready.
      assign pop       = !empty && (hold_mode || bus_io.out_ready[c]);
      // At full, a same-cycle pop frees the slot the push lands in.
      assign accept    = push && (!full || pop);

      assign rd_ptr_d   = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
      assign wr_ptr_d   = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
      assign overflow_d = overflow_q || (push && !accept);

      // Occupancy tracks accepted pushes against pops.
      always_comb begin
         level_d = level_q;
         if (accept && !pop)      level_d = level_q + LW'(1);
         else if (!accept && pop) level_d = level_q - LW'(1);
      end

      // Storage is deliberately left unreset; pointers define what is valid.
      always_ff @(posedge clk_i) begin
         if (accept) mem_q[wr_ptr_q] <= bus_io.wr_data;
      end

      // Pointer, level, sticky flag and hold register update.
      always_ff @(posedge clk_i) begin
         if (!reset_n_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
            held_v_q   <= 1'b0;
         end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            if (hold_mode && pop) begin
               hold_q   <= head;
               held_v_q <= 1'b1;
            end
         end
      end

      // Empty stream channels show zero rather than stale storage.
      assign bus_io.out_data[c*WIDTH +: WIDTH] = hold_mode ? hold_q :
                                                 (empty ? '0 : head);
      assign bus_io.out_valid[c]               = hold_mode ? held_v_q : !empty;
      assign bus_io.level[c*LW +: LW]          = level_q;
      assign bus_io.overflow[c]                = overflow_q;
   end
endmodule

// File: tb/tb_vpi_stim_bank.sv
module tb_vpi_stim_bank;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [31:0] exp_q [4][$];

   always #5 clk = ~clk;

   vpi_stim_bank_if #(.CHANNELS(4), .WIDTH(32), .DEPTH(8)) bus ();
   vpi_stim_bank_if #(.CHANNELS(3), .WIDTH(8), .DEPTH(4))  bus3 ();

   vpi_stim_bank #(.CHANNELS(4), .WIDTH(32), .DEPTH(8)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus_io    (bus)
   );

   vpi_stim_bank #(.CHANNELS(3), .WIDTH(8), .DEPTH(4)) dut3 (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus_io    (bus3)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dat(input int c);
      return bus.out_data[c*32 +: 32];
   endfunction

   function automatic logic [3:0] lvl(input int c);
      return bus.level[c*4 +: 4];
   endfunction

   function automatic logic [2:0] lvl3(input int c);
      return bus3.level[c*3 +: 3];
   endfunction

   task automatic push(input int c, input logic [31:0] d, input bit expect_out);
      bus.wr_en   = 1'b1;
      bus.wr_chan = 2'(c);
      bus.wr_data = d;
      if (expect_out) exp_q[c].push_back(d);
      tick();
      bus.wr_en = 1'b0;
   endtask

   // Stream-mode monitor: every handshake seen ahead of an edge must match the queue head.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int c = 0; c < 4; c++) begin
            if (!bus.mode[c] && bus.out_valid[c] && bus.out_ready[c]) begin
               if (exp_q[c].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_ch%0d: got %0h expected no word", c, dat(c));
               end else begin
                  chk($sformatf("sb_ch%0d", c), 64'(dat(c)), 64'(exp_q[c].pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wr_en = 1'b1; bus.wr_chan = 2'd1; bus.wr_data = 32'hDEAD;
      bus.mode = '0; bus.out_ready = '0;
      bus3.wr_en = 1'b0; bus3.wr_chan = '0; bus3.wr_data = '0;
      bus3.mode = '0; bus3.out_ready = '0;

      // Reset held with a push pending.
      repeat (3) tick();
      chk("rst_level", 64'(bus.level), 64'h0);
      chk("rst_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_data_lo", bus.out_data[63:0], 64'h0);
      chk("rst_data_hi", bus.out_data[127:64], 64'h0);
      chk("rst_cycle", 64'(bus.cycle_count), 64'h0);
      chk("rst_ovf", 64'(bus.overflow), 64'h0);

      reset_n = 1'b1;
      bus.wr_en = 1'b0;
      tick();
      chk("cycle_first", 64'(bus.cycle_count), 64'd1);

      // Stream order on ch1.
      push(1, 32'h11, 1'b1);
      chk("s_valid_first", 64'(bus.out_valid[1]), 64'd1);
      push(1, 32'h22, 1'b1);
      push(1, 32'h33, 1'b1);
      chk("s_level3", 64'(lvl(1)), 64'd3);
      chk("s_head", 64'(dat(1)), 64'h11);
      bus.out_ready[1] = 1'b1;
      repeat (3) tick();
      chk("s_drained_valid", 64'(bus.out_valid[1]), 64'd0);
      chk("s_drained_level", 64'(lvl(1)), 64'd0);
      bus.out_ready[1] = 1'b0;

      // Fill ch0, then one more to overflow.
      for (int i = 0; i < 8; i++) push(0, 32'h100 + 32'(i), 1'b1);
      chk("f_level_full", 64'(lvl(0)), 64'd8);
      chk("f_ovf_before", 64'(bus.overflow[0]), 64'd0);
      push(0, 32'h108, 1'b0);
      chk("f_level_drop", 64'(lvl(0)), 64'd8);
      chk("f_ovf_set", 64'(bus.overflow[0]), 64'd1);
      bus.out_ready[0] = 1'b1;
      push(0, 32'h1FF, 1'b1);
      chk("f_push_pop_full", 64'(lvl(0)), 64'd8);
      repeat (8) tick();
      chk("f_drained", 64'(lvl(0)), 64'd0);
      chk("f_ovf_sticky", 64'(bus.overflow[0]), 64'd1);
      bus.out_ready[0] = 1'b0;

      // Hold mode on ch2.
      bus.mode[2] = 1'b1;
      tick();
      push(2, 32'hA, 1'b0);
      chk("h_valid_early", 64'(bus.out_valid[2]), 64'd0);
      push(2, 32'hB, 1'b0);
      chk("h_first", 64'(dat(2)), 64'hA);
      chk("h_valid", 64'(bus.out_valid[2]), 64'd1);
      tick();
      chk("h_second", 64'(dat(2)), 64'hB);
      tick();
      chk("h_hold", 64'(dat(2)), 64'hB);
      chk("h_valid_kept", 64'(bus.out_valid[2]), 64'd1);
      chk("h_level", 64'(lvl(2)), 64'd0);
      bus.mode[2] = 1'b0;
      #1;
      chk("m_stream_empty", 64'(bus.out_valid[2]), 64'd0);
      bus.mode[2] = 1'b1;
      #1;
      chk("m_hold_back", 64'(dat(2)), 64'hB);

      // Invalid channel on the 3-channel bank.
      bus3.wr_en = 1'b1; bus3.wr_chan = 2'd3; bus3.wr_data = 8'h5A;
      tick();
      chk("inv_levels", 64'(bus3.level), 64'h0);
      chk("inv_ovf", 64'(bus3.overflow), 64'h0);
      bus3.wr_chan = 2'd2;
      tick();
      bus3.wr_en = 1'b0;
      chk("v3_level2", 64'(lvl3(2)), 64'd1);
      chk("v3_data2", 64'(bus3.out_data[23:16]), 64'h5A);

      // Counter wrap.
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_q;
      #1;
      chk("wrap_forced", 64'(bus.cycle_count), 64'hFFFF_FFFE);
      tick();
      chk("wrap_max", 64'(bus.cycle_count), 64'hFFFF_FFFF);
      tick();
      chk("wrap_zero", 64'(bus.cycle_count), 64'h0);

      // Reset mid-operation with ch0 in hold mode.
      for (int i = 0; i < 6; i++) push(0, 32'h60 + 32'(i), 1'b0);
      bus.mode[0] = 1'b1;
      tick();
      chk("r_level5", 64'(lvl(0)), 64'd5);
      chk("r_held", 64'(dat(0)), 64'h60);
      reset_n = 1'b0;
      bus.wr_en = 1'b1; bus.wr_chan = 2'd0; bus.wr_data = 32'h77;
      tick();
      bus.wr_en = 1'b0;
      chk("r_level0", 64'(lvl(0)), 64'd0);
      chk("r_valid0", 64'(bus.out_valid[0]), 64'd0);
      chk("r_data0", 64'(dat(0)), 64'h0);
      chk("r_cycle0", 64'(bus.cycle_count), 64'h0);
      reset_n = 1'b1;
      push(0, 32'h55, 1'b0);
      chk("r_push_level", 64'(lvl(0)), 64'd1);
      chk("r_push_notyet", 64'(bus.out_valid[0]), 64'd0);
      chk("r_cycle1", 64'(bus.cycle_count), 64'd1);
      tick();
      chk("r_push_data", 64'(dat(0)), 64'h55);
      chk("r_push_valid", 64'(bus.out_valid[0]), 64'd1);

      for (int c = 0; c < 4; c++)
         chk($sformatf("sb_left_ch%0d", c), 64'(exp_q[c].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
